// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to instruction memory boot loader
// Holds the datapath in reset until a checksum-verified image has been written.
module program_loader #(
  parameter int          MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        imemWrite,
  output logic [31:0] imemAddress,
  output logic [31:0] imemData,
  output logic        cpuReset,
  output logic        loadDone,
  output logic        loadError
);

  typedef enum logic [2:0] {
    IDLE, COUNT_LO, COUNT_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [15:0] word_count;
  logic [15:0] word_index;
  logic [1:0]  lane;
  logic [7:0]  checksum;
  logic [23:0] partial;

  logic        fire;
  logic [15:0] count_full;
  logic        count_bad;
  logic        last_lane;
  logic        last_word;
  logic        ready_next;

  assign fire       = byteValid && byteReady;
  assign count_full = {byteData, word_count[7:0]};
  assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > MAX_COUNT);
  assign last_lane  = (lane == 2'd3);
  assign last_word  = ((word_index + 16'd1) == word_count);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (fire && byteData == SYNC_BYTE) state_next = COUNT_LO;
      COUNT_LO: if (fire) state_next = COUNT_HI;
      COUNT_HI: if (fire) state_next = count_bad ? ERROR : DATA;
      DATA:     if (fire && last_lane && last_word) state_next = CHECK;
      CHECK:    if (fire) state_next = (byteData == checksum) ? DONE : ERROR;
      default:  state_next = state;
    endcase
    ready_next = (state_next != DONE) && (state_next != ERROR);
  end

  // Ready is registered from the next state so it never depends on byteValid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      byteReady   <= 1'b0;
      imemWrite   <= 1'b0;
      imemAddress <= BASE_ADDR;
      imemData    <= 32'd0;
      cpuReset    <= 1'b1;
      loadDone    <= 1'b0;
      loadError   <= 1'b0;
      word_count  <= 16'd0;
      word_index  <= 16'd0;
      lane        <= 2'd0;
      checksum    <= 8'd0;
      partial     <= 24'd0;
    end else begin
      state     <= state_next;
      byteReady <= ready_next;
      imemWrite <= 1'b0;
      cpuReset  <= (state_next != DONE);
      loadDone  <= (state_next == DONE);
      loadError <= (state_next == ERROR);
      case (state)
        IDLE: begin
          word_count <= 16'd0;
          word_index <= 16'd0;
          lane       <= 2'd0;
          checksum   <= 8'd0;
        end
        COUNT_LO: if (fire) word_count[7:0] <= byteData;
        COUNT_HI: if (fire) word_count[15:8] <= byteData;
        DATA: if (fire) begin
          checksum <= checksum ^ byteData;
          lane     <= lane + 2'd1;
          if (last_lane) begin
            imemWrite   <= 1'b1;
            imemData    <= {byteData, partial};
            imemAddress <= BASE_ADDR + {14'd0, word_index, 2'b00};
            word_index  <= word_index + 16'd1;
          end else begin
            partial[{lane, 3'b000} +: 8] <= byteData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
